// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared constants, pointer code conversions and arbiter state encoding for
// the async FIFO write/read controllers.
package fifo_pkg;

  localparam int FIFO_ADDR_W = 5;
  localparam int FIFO_DEPTH  = 2**FIFO_ADDR_W;

  // Conversion helpers work on a wide vector; callers zero-extend their
  // pointer in and truncate the result back to pointer width.
  localparam int PTR_MAX_W = 16;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side handshake bundle: N_REQ producers each offer one word per
// cycle; the arbiter answers with a one-hot ready.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;

  modport master (output req_valid, output req_last, output req_data, input req_ready);
  modport slave  (input req_valid, input req_last, input req_data, output req_ready);
endinterface

// File: rtl/fifo_wr_arbiter_ptr_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing clock domains.
// Shared by the write-side and read-side controllers.
module ptr_sync_2ff #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         arstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  // Two register stages to resolve metastability on the incoming pointer.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side controller of the async FIFO: round-robin arbitration with burst
// lock over N_REQ producers, write pointer ownership and full/almost-full flags.
//
// state | meaning
// ARB   | free arbitration; a last=1 word advances the round-robin pointer
// LOCK  | burst in progress; only the owner may be granted, bubbles allowed
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = FIFO_ADDR_W,
  parameter int AF_THRESH = 28,
  parameter int CNT_W     = 16
) (
  input  logic                       w_clk,
  input  logic                       arstn,
  fifo_wr_arbiter_if.slave           prod,
  input  logic [ADDR_W:0]            rptr_gray,
  output logic [ADDR_W:0]            wptr_gray,
  output logic                       mem_w_en,
  output logic                       mem_full,
  output logic [DATA_W-1:0]          mem_data,
  output logic [ADDR_W:0]            mem_w_ptr,
  output logic                       almost_full,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       locked,
  output logic [CNT_W-1:0]           wr_count
);
  localparam int GW = $clog2(N_REQ);
  localparam int PW = ADDR_W + 1;
  localparam logic [ADDR_W:0] AF_LVL = PW'(AF_THRESH);

  arb_state_t       state, state_nxt;
  logic [GW-1:0]    rr_ptr, owner, pick, grant_sel, rr_inc;
  logic             pick_vld, grant_vld, grant_last, xfer, full;
  logic [N_REQ-1:0] ready_vec;
  logic [ADDR_W:0]  wbin, wbin_next, wgray_next, rq2, rbin, fill, full_cmp;

  ptr_sync_2ff #(.W(PW)) u_rptr_sync (
    .clk   (w_clk),
    .arstn (arstn),
    .d     (rptr_gray),
    .q     (rq2)
  );

  // Round-robin pick: first valid producer at or after rr_ptr, circularly.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!pick_vld && prod.req_valid[idx]) begin
        pick     = GW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // Grant selection; during a burst the owner is the only candidate.
  // Ready is also held off while reset is asserted so no word is half-taken.
  always_comb begin
    grant_sel = pick;
    grant_vld = pick_vld;
    if (state == LOCK) begin
      grant_sel = owner;
      grant_vld = prod.req_valid[owner];
    end
    xfer       = grant_vld && !full && arstn;
    grant_last = prod.req_last[grant_sel];
    ready_vec  = '0;
    if (xfer) ready_vec[grant_sel] = 1'b1;
    rr_inc     = (grant_sel == GW'(N_REQ-1)) ? '0 : grant_sel + GW'(1);
  end

  assign prod.req_ready = ready_vec;
  assign mem_w_en       = xfer;
  assign mem_full       = full;
  assign mem_data       = prod.req_data[grant_sel*DATA_W +: DATA_W];
  assign mem_w_ptr      = {1'b0, wbin[ADDR_W-1:0]};

  // Pointer arithmetic feeding the registered flags.
  always_comb begin
    wbin_next  = wbin + PW'(xfer);
    wgray_next = PW'(bin2gray(PTR_MAX_W'(wbin_next)));
    rbin       = PW'(gray2bin(PTR_MAX_W'(rq2)));
    fill       = wbin_next - rbin;
    full_cmp   = {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]};
  end

  // Arbiter state register.
  always_ff @(posedge w_clk or negedge arstn) begin
    if (!arstn) state <= ARB;
    else        state <= state_nxt;
  end

  // Next-state and lock indication.
  always_comb begin
    state_nxt = state;
    locked    = (state == LOCK);
    case (state)
      ARB:     if (xfer && !grant_last) state_nxt = LOCK;
      LOCK:    if (xfer && grant_last)  state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // Pointers, flags, round-robin bookkeeping and the accepted-word counter.
  always_ff @(posedge w_clk or negedge arstn) begin
    if (!arstn) begin
      rr_ptr      <= '0;
      owner       <= '0;
      grant_id    <= '0;
      wbin        <= '0;
      wptr_gray   <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_count    <= '0;
    end else begin
      wbin        <= wbin_next;
      wptr_gray   <= wgray_next;
      full        <= (wgray_next == full_cmp);
      almost_full <= (fill >= AF_LVL);
      if (xfer) begin
        grant_id <= grant_sel;
        wr_count <= wr_count + CNT_W'(1);
        if (grant_last)         rr_ptr <= rr_inc;
        else if (state == ARB)  owner  <= grant_sel;
      end
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producer queues drive the handshake, expected
// memory writes go into a scoreboard that a negedge monitor drains.
module tb_fifo_wr_arbiter;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int CW = 16;

  logic          w_clk = 1'b0;
  logic          arstn;
  logic [AW:0]   rptr_gray, wptr_gray, mem_w_ptr;
  logic          mem_w_en, mem_full, almost_full, locked;
  logic [DW-1:0] mem_data;
  logic [1:0]    grant_id;
  logic [CW-1:0] wr_count;

  always #5 w_clk = ~w_clk;

  fifo_wr_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW), .AF_THRESH(28), .CNT_W(CW)) dut (
    .w_clk       (w_clk),
    .arstn       (arstn),
    .prod        (bus),
    .rptr_gray   (rptr_gray),
    .wptr_gray   (wptr_gray),
    .mem_w_en    (mem_w_en),
    .mem_full    (mem_full),
    .mem_data    (mem_data),
    .mem_w_ptr   (mem_w_ptr),
    .almost_full (almost_full),
    .grant_id    (grant_id),
    .locked      (locked),
    .wr_count    (wr_count)
  );

  typedef struct packed {logic [DW-1:0] data; logic last;} word_t;
  typedef struct {int id; logic [DW-1:0] data; logic [AW:0] ptr;} exp_t;

  word_t      src_q [N][$];
  exp_t       exp_q [$];
  logic [N-1:0] en;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] dv(input int id, input int k);
    return DW'(id*64 + k);
  endfunction

  task automatic src_push(input int id, input logic [DW-1:0] d, input logic last);
    word_t w;
    w.data = d;
    w.last = last;
    src_q[id].push_back(w);
  endtask

  task automatic exp_push(input int id, input logic [DW-1:0] d, input logic [AW:0] p);
    exp_t e;
    e.id = id;
    e.data = d;
    e.ptr = p;
    exp_q.push_back(e);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (en[i] && src_q[i].size() > 0) begin
        bus.req_valid[i]           = 1'b1;
        bus.req_last[i]            = src_q[i][0].last;
        bus.req_data[i*DW +: DW]   = src_q[i][0].data;
      end else begin
        bus.req_valid[i]           = 1'b0;
        bus.req_last[i]            = 1'b0;
        bus.req_data[i*DW +: DW]   = '0;
      end
    end
  endtask

  // One clock: sample handshakes at negedge, retire accepted words after the edge.
  task automatic step();
    logic [N-1:0] fire;
    @(negedge w_clk);
    fire = (arstn === 1'b1) ? (bus.req_valid & bus.req_ready) : '0;
    @(posedge w_clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    drive();
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((src_q[0].size() + src_q[1].size() + src_q[2].size()) != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_pending", src_q[0].size() + src_q[1].size() + src_q[2].size(), 0);
  endtask

  task automatic do_reset();
    arstn = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    en = '0;
    rptr_gray = '0;
    drive();
    repeat (2) @(posedge w_clk);
    #1;
    arstn = 1'b1;
  endtask

  // Scoreboard monitor: every memory write must match the next expected entry.
  always @(negedge w_clk) begin
    if (arstn === 1'b1 && mem_w_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: ptr %0d data %0h, expected no write", mem_w_ptr, mem_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_data", 32'(mem_data), 32'(e.data));
        check("wr_ptr", 32'(mem_w_ptr), 32'(e.ptr));
        check("wr_ready", 32'(bus.req_ready), 32'(1) << e.id);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [AW:0] wbv, g, prev;

    // T1: reset state
    arstn = 1'b0;
    rptr_gray = '0;
    en = '0;
    drive();
    #3;
    check("rst_wptr_gray", 32'(wptr_gray), 0);
    check("rst_mem_w_en", 32'(mem_w_en), 0);
    check("rst_full", 32'(mem_full), 0);
    check("rst_almost_full", 32'(almost_full), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_wr_count", 32'(wr_count), 0);
    check("rst_ready", 32'(bus.req_ready), 0);
    check("rst_mem_w_ptr", 32'(mem_w_ptr), 0);
    @(posedge w_clk);
    #1;
    arstn = 1'b1;
    repeat (2) step();
    check("idle_wr_count", 32'(wr_count), 0);

    // T2: all valid, single-word transfers rotate 0,1,2,0
    src_push(0, dv(0, 0), 1'b1);
    src_push(0, dv(0, 1), 1'b1);
    src_push(1, dv(1, 0), 1'b1);
    src_push(2, dv(2, 0), 1'b1);
    exp_push(0, dv(0, 0), 6'd0);
    exp_push(1, dv(1, 0), 6'd1);
    exp_push(2, dv(2, 0), 6'd2);
    exp_push(0, dv(0, 1), 6'd3);
    en = '1;
    drive();
    run_until_idle(10);
    step();
    check("t2_wr_count", 32'(wr_count), 4);
    check("t2_grant_id", 32'(grant_id), 0);
    check("t2_sb_empty", exp_q.size(), 0);

    // T3: req1 4-word burst with a bubble, req0/req2 competing
    for (int k = 0; k < 4; k++) src_push(1, dv(1, 10 + k), (k == 3));
    src_push(0, dv(0, 10), 1'b1);
    src_push(2, dv(2, 10), 1'b1);
    for (int k = 0; k < 4; k++) exp_push(1, dv(1, 10 + k), 6'(4 + k));
    exp_push(2, dv(2, 10), 6'd8);
    exp_push(0, dv(0, 10), 6'd9);
    drive();
    step();
    check("t3_locked_start", 32'(locked), 1);
    step();
    en[1] = 1'b0;
    drive();
    step();
    step();
    check("t3_locked_bubble", 32'(locked), 1);
    check("t3_bubble_count", 32'(wr_count), 6);
    en[1] = 1'b1;
    drive();
    run_until_idle(20);
    step();
    check("t3_locked_end", 32'(locked), 0);
    check("t3_wr_count", 32'(wr_count), 10);
    check("t3_grant_id", 32'(grant_id), 0);
    check("t3_sb_empty", exp_q.size(), 0);

    // T4: fill to full, blocked write, release by read pointer advance
    do_reset();
    for (int k = 0; k < 33; k++) src_push(0, dv(0, k), 1'b1);
    for (int k = 0; k < 32; k++) exp_push(0, dv(0, k), 6'(k));
    en = 3'b001;
    drive();
    repeat (27) step();
    check("t4_af_at_27", 32'(almost_full), 0);
    check("t4_full_at_27", 32'(mem_full), 0);
    step();
    check("t4_af_at_28", 32'(almost_full), 1);
    repeat (3) step();
    check("t4_full_at_31", 32'(mem_full), 0);
    step();
    check("t4_full_at_32", 32'(mem_full), 1);
    check("t4_count_32", 32'(wr_count), 32);
    check("t4_ready_when_full", 32'(bus.req_ready), 0);
    check("t4_wen_when_full", 32'(mem_w_en), 0);
    repeat (3) step();
    check("t4_33rd_pending", src_q[0].size(), 1);
    check("t4_count_hold", 32'(wr_count), 32);
    check("t4_full_hold", 32'(mem_full), 1);
    exp_push(0, dv(0, 32), 6'd0);
    rptr_gray = 6'b000001;
    repeat (3) step();
    check("t4_full_cleared", 32'(mem_full), 0);
    run_until_idle(5);
    step();
    check("t4_count_33", 32'(wr_count), 33);
    check("t4_sb_empty", exp_q.size(), 0);

    // T5: reader keeps pace; 70 writes, Gray pointer and wrap behaviour
    do_reset();
    for (int k = 0; k < 70; k++) begin
      src_push(1, dv(1, k), 1'b1);
      exp_push(1, dv(1, k), 6'(k % 32));
    end
    en = 3'b010;
    drive();
    prev = '0;
    for (int k = 1; k <= 70; k++) begin
      step();
      wbv = 6'(k);
      g = wbv ^ (wbv >> 1);
      check("t5_wptr_gray", 32'(wptr_gray), 32'(g));
      check("t5_gray_one_bit", $countones(g ^ prev) == 1 ? $countones(wptr_gray ^ prev) : 0, 1);
      if (k == 32) check("t5_msb_at_32", 32'(wptr_gray[AW]), 1);
      if (k == 64) check("t5_msb_at_64", 32'(wptr_gray[AW]), 0);
      prev = g;
      rptr_gray = g;
    end
    check("t5_wr_count", 32'(wr_count), 70);
    check("t5_sb_empty", exp_q.size(), 0);

    // T6: reset in the middle of a req0 burst
    do_reset();
    for (int k = 0; k < 4; k++) src_push(0, dv(0, 40 + k), (k == 3));
    src_push(2, dv(2, 40), 1'b1);
    exp_push(0, dv(0, 40), 6'd0);
    en = '1;
    drive();
    step();
    check("t6_locked_before", 32'(locked), 1);
    check("t6_count_before", 32'(wr_count), 1);
    #2;
    arstn = 1'b0;
    #1;
    check("t6_async_locked", 32'(locked), 0);
    check("t6_async_count", 32'(wr_count), 0);
    check("t6_async_wptr_gray", 32'(wptr_gray), 0);
    check("t6_async_mem_w_ptr", 32'(mem_w_ptr), 0);
    check("t6_async_wen", 32'(mem_w_en), 0);
    check("t6_async_ready", 32'(bus.req_ready), 0);
    src_q[0].delete();
    en[0] = 1'b0;
    for (int k = 0; k < 4; k++) src_push(0, dv(0, 50 + k), (k == 3));
    drive();
    @(posedge w_clk);
    #1;
    arstn = 1'b1;
    exp_push(2, dv(2, 40), 6'd0);
    step();
    check("t6_first_grant", 32'(grant_id), 2);
    check("t6_count_first", 32'(wr_count), 1);
    en[0] = 1'b1;
    for (int k = 0; k < 4; k++) exp_push(0, dv(0, 50 + k), 6'(1 + k));
    drive();
    run_until_idle(10);
    step();
    check("t6_wr_count", 32'(wr_count), 5);
    check("t6_locked_end", 32'(locked), 0);
    check("t6_sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
